// File: rtl/apb_timer_pkg.sv
// Shared types and register map for the APB timer/compare peripheral.
// Offsets are word indices (byte offset >> 2) matching paddr[4:2].
package apb_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [2:0] OFS_CTRL     = 3'd0;
  localparam logic [2:0] OFS_PRESCALE = 3'd1;
  localparam logic [2:0] OFS_COUNT    = 3'd2;
  localparam logic [2:0] OFS_COMPARE  = 3'd3;
  localparam logic [2:0] OFS_STATUS   = 3'd4;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;

  function automatic logic is_mapped(input logic [2:0] ofs);
    return ofs <= OFS_STATUS;
  endfunction

endpackage

// File: rtl/apb_slave_fsm.sv
// Generic APB completer handshake: IDLE/SETUP/ACCESS with WAIT_STATES access
// cycles before PREADY; emits one-cycle read/write strobes on completion.
module apb_slave_fsm
  import apb_timer_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_psel,
  input  logic i_penable,
  input  logic i_pwrite,
  output logic o_pready,
  output logic o_wr_strobe,
  output logic o_rd_strobe
);

  localparam logic [2:0] WS_INIT = 3'(WAIT_STATES);

  apb_state_e state_q, state_d;
  logic [2:0] ws_cnt_q, ws_cnt_d;

  // NOTE: defaults are assigned first so every path drives state_d/ws_cnt_d
  // and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    ws_cnt_d = ws_cnt_q;
    case (state_q)
      IDLE: begin
        if (i_psel && !i_penable) begin
          state_d  = SETUP;
          ws_cnt_d = WS_INIT;
        end
      end
      SETUP: begin
        if (!i_psel)        state_d = IDLE;
        else if (i_penable) state_d = ACCESS;
      end
      ACCESS: begin
        if (!i_psel) begin
          state_d = IDLE;
        end else if (!i_penable) begin
          // Master opened a new setup phase: restart the handshake.
          state_d  = SETUP;
          ws_cnt_d = WS_INIT;
        end else if (ws_cnt_q != 3'd0) begin
          ws_cnt_d = ws_cnt_q - 3'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      ws_cnt_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      ws_cnt_q <= ws_cnt_d;
    end
  end

  assign o_pready    = (state_q == ACCESS) && i_psel && i_penable && (ws_cnt_q == 3'd0);
  assign o_wr_strobe = o_pready && i_pwrite;
  assign o_rd_strobe = o_pready && !i_pwrite;

endmodule

// File: rtl/apb_timer_slave.sv
// APB timer/compare peripheral: CTRL, PRESCALE, COUNT, COMPARE, STATUS(W1C).
// Define APB_TIMER_SLVERR_EN to add o_pslverr for unmapped/illegal accesses.
module apb_timer_slave
  import apb_timer_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int PRESCALE_W  = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_paddr,
  input  logic        i_pwrite,
  input  logic        i_psel,
  input  logic        i_penable,
  input  logic [31:0] i_pwdata,
  output logic [31:0] o_prdata,
  output logic        o_pready,
  output logic        o_irq
`ifdef APB_TIMER_SLVERR_EN
  ,
  output logic        o_pslverr
`endif
);

  logic [2:0] ofs;
  logic       wr_strobe, rd_strobe;
  logic       access_err, wr_en;
  logic       unused_addr;

  assign ofs         = i_paddr[4:2];
  assign unused_addr = ^{i_paddr[31:5], i_paddr[1:0]};

  apb_slave_fsm #(
    .WAIT_STATES(WAIT_STATES)
  ) u_fsm (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_psel     (i_psel),
    .i_penable  (i_penable),
    .i_pwrite   (i_pwrite),
    .o_pready   (o_pready),
    .o_wr_strobe(wr_strobe),
    .o_rd_strobe(rd_strobe)
  );

`ifdef APB_TIMER_SLVERR_EN
  // An erroring write is dropped whole, including a W1C of STATUS[0].
  assign access_err = !is_mapped(ofs) ||
                      (i_pwrite && (ofs == OFS_STATUS) && (i_pwdata[31:1] != 31'd0));
  assign o_pslverr  = o_pready && access_err;
`else
  assign access_err = 1'b0;
`endif

  assign wr_en = wr_strobe && !access_err;

  logic wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
  assign wr_ctrl     = wr_en && (ofs == OFS_CTRL);
  assign wr_prescale = wr_en && (ofs == OFS_PRESCALE);
  assign wr_count    = wr_en && (ofs == OFS_COUNT);
  assign wr_compare  = wr_en && (ofs == OFS_COMPARE);
  assign wr_status   = wr_en && (ofs == OFS_STATUS);

  logic [2:0]            ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic                  match_q, match_d;
  logic                  tick, hit;

  assign tick = ctrl_q[CTRL_EN] && (pre_cnt_q == prescale_q);
  assign hit  = tick && (count_q == compare_q);

  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    pre_cnt_d  = pre_cnt_q;
    count_d    = count_q;
    compare_d  = compare_q;
    match_d    = match_q;

    if (ctrl_q[CTRL_EN]) pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    if (tick) count_d = (hit && ctrl_q[CTRL_AUTO_RELOAD]) ? 32'd0 : count_q + 32'd1;

    if (wr_ctrl)    ctrl_d    = i_pwdata[2:0];
    if (wr_compare) compare_d = i_pwdata;
    if (wr_count)   count_d   = i_pwdata;
    if (wr_prescale) begin
      prescale_d = i_pwdata[PRESCALE_W-1:0];
      pre_cnt_d  = '0;
    end

    // A match being set this cycle overrides a simultaneous clear.
    if (wr_status && i_pwdata[0]) match_d = 1'b0;
    if (hit)                      match_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      match_q    <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
    end
  end

  logic [31:0] rdata;
  always_comb begin
    rdata = 32'd0;
    case (ofs)
      OFS_CTRL:     rdata = {29'd0, ctrl_q};
      OFS_PRESCALE: rdata = 32'(prescale_q);
      OFS_COUNT:    rdata = count_q;
      OFS_COMPARE:  rdata = compare_q;
      OFS_STATUS:   rdata = {31'd0, match_q};
      default:      rdata = 32'd0;
    endcase
  end

  assign o_prdata = rd_strobe ? rdata : 32'd0;
  assign o_irq    = match_q && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave: one instance with WAIT_STATES=1 and one
// with WAIT_STATES=0 share the bus; each has its own select.
module tb_apb_timer_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr, pwdata;
  logic        pwrite, penable, psel1, psel0;
  logic [31:0] prdata1, prdata0;
  logic        pready1, pready0, irq1, irq0;
`ifdef APB_TIMER_SLVERR_EN
  logic        slverr1, slverr0;
`endif

  always #5 clk = ~clk;

  apb_timer_slave #(.WAIT_STATES(1), .PRESCALE_W(16)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_paddr(paddr), .i_pwrite(pwrite),
    .i_psel(psel1), .i_penable(penable), .i_pwdata(pwdata),
    .o_prdata(prdata1), .o_pready(pready1), .o_irq(irq1)
`ifdef APB_TIMER_SLVERR_EN
    , .o_pslverr(slverr1)
`endif
  );

  apb_timer_slave #(.WAIT_STATES(0), .PRESCALE_W(16)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_paddr(paddr), .i_pwrite(pwrite),
    .i_psel(psel0), .i_penable(penable), .i_pwdata(pwdata),
    .o_prdata(prdata0), .o_pready(pready0), .o_irq(irq0)
`ifdef APB_TIMER_SLVERR_EN
    , .o_pslverr(slverr0)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_idle();
    @(negedge clk);
    psel1   = 1'b0;
    psel0   = 1'b0;
    penable = 1'b0;
  endtask

  // Full transfer: setup at the first negedge, penable at the next; returns
  // #1 after the negedge of the PREADY cycle. lat = cycles from setup to PREADY.
  task automatic xfer(input bit use0, input logic [31:0] addr, input bit wr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output int lat, output logic err);
    bit done;
    done  = 1'b0;
    rdata = 32'd0;
    err   = 1'b0;
    @(negedge clk);
    psel1   = !use0;
    psel0   = use0;
    penable = 1'b0;
    paddr   = addr;
    pwrite  = wr;
    pwdata  = wdata;
    @(negedge clk);
    penable = 1'b1;
    lat     = 1;
    while (!done && lat < 20) begin
      #1;
      if (use0 ? pready0 : pready1) begin
        done  = 1'b1;
        rdata = use0 ? prdata0 : prdata1;
`ifdef APB_TIMER_SLVERR_EN
        err   = use0 ? slverr0 : slverr1;
`endif
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    if (!done) check("xfer_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr1(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    int          lat;
    logic        err;
    xfer(1'b0, addr, 1'b1, data, rd, lat, err);
  endtask

  task automatic rd1(input logic [31:0] addr, output logic [31:0] data);
    int   lat;
    logic err;
    xfer(1'b0, addr, 1'b0, 32'd0, data, lat, err);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        err;
    int          waited;

    rst = 1'b1; paddr = '0; pwdata = '0; pwrite = 1'b0;
    penable = 1'b0; psel1 = 1'b0; psel0 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_pready1", pready1, 0);
    check("rst_prdata1", prdata1, 0);
    check("rst_irq1",    irq1,    0);
    check("rst_pready0", pready0, 0);
    check("rst_prdata0", prdata0, 0);
    check("rst_irq0",    irq0,    0);
    @(negedge clk);
    rst = 1'b0;

    // Every offset reads 0 after reset; WAIT_STATES=1 -> PREADY 3 cycles in.
    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, 32'(i * 4), 1'b0, 32'd0, rd, lat, err);
      check($sformatf("rst_read_%0h", i * 4), rd, 0);
      if (i == 0) check("lat_ws1", lat, 3);
    end
    apb_idle();

    // Compare with auto-reload, tick every cycle.
    wr1(32'h0C, 32'd5);
    wr1(32'h04, 32'd0);
    wr1(32'h00, 32'h7);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      psel1 = 1'b0; penable = 1'b0;
      #1;
      check($sformatf("step_count_%0d", k), u_dut1.count_q, (k < 6) ? k : 0);
      if (k == 5) check("irq_before_match", irq1, 0);
      if (k == 6) check("irq_after_match", irq1, 1);
    end

    wr1(32'h00, 32'h0);
    wr1(32'h08, 32'h0);
    wr1(32'h10, 32'h1);
    rd1(32'h10, rd);
    check("status_cleared", rd, 0);

    // PRESCALE=3: one tick every 4 cycles.
    wr1(32'h04, 32'd3);
    wr1(32'h00, 32'h1);
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      psel1 = 1'b0; penable = 1'b0;
      #1;
      check($sformatf("pre3_count_%0d", k), u_dut1.count_q, (k - 1) / 4);
    end

    wr1(32'h08, 32'hFFFF_FFFF);
    @(negedge clk);
    psel1 = 1'b0; penable = 1'b0;
    #1;
    check("count_written", u_dut1.count_q, 32'hFFFF_FFFF);
    waited = 0;
    while (u_dut1.count_q == 32'hFFFF_FFFF && waited < 8) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("count_wrap", u_dut1.count_q, 0);
    check("wrap_within_prescale", (waited <= 4) ? 1 : 0, 1);

    // W1C on the same edge as a match tick: with CTRL committed at P0, the
    // next write's commit edge is P0+4, where COUNT==3 is ticked.
    wr1(32'h00, 32'h0);
    wr1(32'h04, 32'd0);
    wr1(32'h0C, 32'd3);
    wr1(32'h08, 32'd0);
    wr1(32'h10, 32'h1);
    wr1(32'h00, 32'h7);
    wr1(32'h10, 32'h1);
    @(negedge clk);
    psel1 = 1'b0; penable = 1'b0;
    #1;
    check("w1c_collide_match", u_dut1.match_q, 1);
    check("w1c_collide_irq", irq1, 1);
    wr1(32'h00, 32'h4);
    apb_idle();
    #1;
    check("irq_held_disabled", irq1, 1);
    wr1(32'h10, 32'h1);
    apb_idle();
    #1;
    check("w1c_irq_low", irq1, 0);
    rd1(32'h10, rd);
    check("w1c_status", rd, 0);
    apb_idle();

    // Back-to-back on the zero-wait-state instance.
    xfer(1'b1, 32'h0C, 1'b1, 32'hDEAD_BEEF, rd, lat, err);
    check("b2b_wr_lat", lat, 2);
    xfer(1'b1, 32'h0C, 1'b0, 32'd0, rd, lat, err);
    check("b2b_rd_lat", lat, 2);
    check("b2b_rd_data", rd, 32'hDEAD_BEEF);
    @(negedge clk);
    #1;
    check("pready_one_cycle", pready0, 0);
    apb_idle();

    // Reset while a COUNT write is in its PREADY cycle.
    @(negedge clk);
    psel1 = 1'b1; penable = 1'b0; paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h1234;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_reset_pready", pready1, 1);
    rst = 1'b1;
    #1;
    check("reset_pready_drop", pready1, 0);
    @(negedge clk);
    rst = 1'b0; psel1 = 1'b0; penable = 1'b0;
    #1;
    check("reset_count_zero", u_dut1.count_q, 0);
    rd1(32'h08, rd);
    check("reset_count_read", rd, 0);
    rd1(32'h0C, rd);
    check("reset_compare_read", rd, 0);
    apb_idle();

`ifdef APB_TIMER_SLVERR_EN
    xfer(1'b0, 32'h18, 1'b0, 32'd0, rd, lat, err);
    check("slverr_unmapped", err, 1);
    check("slverr_rdata", rd, 0);
    xfer(1'b0, 32'h08, 1'b0, 32'd0, rd, lat, err);
    check("slverr_mapped", err, 0);
    apb_idle();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_timer_slave.md
Name: apb_timer_slave

Overview:
APB completer (slave) for the external APB bus driven by the core's MEM-stage master. Implements a memory-mapped 32-bit timer/compare peripheral with a programmable number of wait states. A top-level decoder asserts i_psel for the peripheral's region. Returns read data and PREADY to the master, which stalls the pipeline until PREADY goes high.

Parameters:
- WAIT_STATES, 1, access-phase cycles with o_pready low before completion; legal range 0..7.
- PRESCALE_W, 16, width of the PRESCALE register.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_paddr  in  32  byte address; only [4:2] decoded.
- i_pwrite  in  1  1=write, 0=read.
- i_psel  in  1  peripheral select.
- i_penable  in  1  access phase.
- i_pwdata  in  32  write data.
- o_prdata  out  32  read data.
- o_pready  out  1  transfer complete.
- o_irq  out  1  level interrupt: STATUS.match & CTRL.irq_en.

Behaviour:
- Reset values:
  - all registers 0; FSM in IDLE; wait counter ws_cnt=0.
  - o_pready=0, o_prdata=0, o_irq=0.
- Register map (offset):
  - 0x00 CTRL: [0] en, [1] auto_reload, [2] irq_en; other bits read 0.
  - 0x04 PRESCALE: [PRESCALE_W-1:0].
  - 0x08 COUNT: RW.
  - 0x0C COMPARE: RW.
  - 0x10 STATUS: [0] match; write-1-to-clear.
  - 0x14..0x1C: read 0; writes ignored.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when i_psel & !i_penable; ws_cnt <= WAIT_STATES.
  - SETUP -> ACCESS when i_psel & i_penable.
  - ACCESS with ws_cnt!=0: decrement ws_cnt, o_pready=0.
  - ACCESS with ws_cnt==0: o_pready=1 for exactly one cycle, then go to SETUP if (i_psel & !i_penable), else IDLE. This supports back-to-back transfers.
  - i_psel dropping mid-transfer (protocol violation): return to IDLE; no register side effects.
- o_pready is combinational: (state==ACCESS) & i_psel & i_penable & (ws_cnt==0).
- Latency: WAIT_STATES=0 gives a 2-cycle transfer (setup + access); each wait state adds 1 cycle.
- Read: o_prdata is a combinational register mux, valid only while o_pready & !i_pwrite; 0 otherwise.
- Write: commits on the rising edge where o_pready & i_pwrite. Read value is pre-write.
- Timer:
  - When en=1: pre_cnt increments each cycle. At pre_cnt==PRESCALE, pre_cnt<=0 and a tick is issued. PRESCALE=0 ticks every cycle.
  - On tick, if COUNT==COMPARE: set match; COUNT <= auto_reload ? 0 : COUNT+1.
  - On tick otherwise: COUNT <= COUNT+1, wrapping 0xFFFFFFFF -> 0.
  - en=0: pre_cnt and COUNT hold.
- Collisions:
  - APB write to COUNT in the same cycle as a tick: the write wins.
  - Any write to PRESCALE clears pre_cnt.
  - STATUS W1C in the same cycle as a match set: set wins (match stays 1).
- Async reset mid-transfer: FSM to IDLE, o_pready=0 immediately; the pending write is discarded.

Optional Feature:
- Macro: APB_TIMER_SLVERR_EN.
- Defined:
  - adds port o_pslverr out 1.
  - Asserted with o_pready for access to unmapped offsets 0x14..0x1C, or a write to STATUS bits other than [0]. The write is then discarded entirely, including a W1C of bit 0.
  - Otherwise 0; reset 0.
- Undefined: no port; unmapped accesses complete silently as above.

Decomposition:
- Package apb_timer_pkg holds:
  - typedef enum apb_state_e {IDLE, SETUP, ACCESS};
  - localparams for register offsets (OFS_CTRL..OFS_STATUS) and CTRL bit indices.
- Sub-module apb_slave_fsm:
  - owns the FSM, ws_cnt and o_pready.
  - exports wr_strobe and rd_strobe.
  - reusable by future APB peripherals.
- The register file and timer logic stay in apb_timer_slave.

Test Plan:
- Reset with transfers idle -> all outputs 0. Read each offset 0x00..0x1C -> 0. With WAIT_STATES=1, o_pready is high exactly 3 cycles after i_psel rises.
- Write COMPARE=5, PRESCALE=0, CTRL=0x7 -> COUNT steps 0..5; match=1 and o_irq=1 on the cycle after COUNT==5 is ticked; COUNT returns to 0.
- Write PRESCALE=3, CTRL=0x1 -> COUNT increments once every 4 cycles. Write COUNT=0xFFFFFFFF -> COUNT wraps to 0 on the next tick.
- W1C STATUS=1 coinciding with a match tick -> match remains 1. A later W1C with no tick -> match=0, o_irq=0.
- Back-to-back write then read of COMPARE with WAIT_STATES=0 -> each completes in 2 cycles; the read returns the written value 0xDEADBEEF.
- Assert i_reset during the ACCESS wait of a COUNT write -> o_pready=0 immediately and COUNT stays 0. With APB_TIMER_SLVERR_EN, a read of 0x18 -> o_pslverr=1 and o_prdata=0.
